// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// read/write strobe values and a width helper.
// Optional feature macro: MEM_RESPONDER_ERR_EN (out-of-range error reporting).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Handshake bus between an initiator (fetch/execute FSMs with MAR/MDR)
// and the memory responder.
// Optional feature macro: MEM_RESPONDER_ERR_EN adds the err signal.
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              memEN;
    logic              RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              MFC;
    logic              busy;
`ifdef MEM_RESPONDER_ERR_EN
    logic              err;

    modport master (output memEN, RW, addr, wdata, input rdata, MFC, busy, err);
    modport slave  (input memEN, RW, addr, wdata, output rdata, MFC, busy, err);
`else
    modport master (output memEN, RW, addr, wdata, input rdata, MFC, busy);
    modport slave  (input memEN, RW, addr, wdata, output rdata, MFC, busy);
`endif
endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Contents are never reset; only the read register is.
// Optional feature macro: MEM_RESPONDER_ERR_EN (drives rzero from the top).
module mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              rzero,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: changes only on a completed read (or a suppressed one).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rzero) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the memEN/RW/MFC handshake. Captures the
// request on memEN, waits WAIT_CYCLES, performs the access, then holds MFC
// until the initiator releases memEN.
// Optional feature macro: MEM_RESPONDER_ERR_EN -- addresses >= DEPTH are
// suppressed and flagged on err instead of wrapping modulo DEPTH.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = idx_width(WAIT_CYCLES + 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rw_q;
    logic [IDX_W-1:0]    idx;
    logic                fire;
    logic                we;
    logic                re;
    logic                rzero;
    logic [DATA_W-1:0]   rdata;
    logic                capture;

    assign capture = (state == IDLE) && bus.memEN;

    // Access happens on the edge where the wait counter has drained; a
    // reset on that same edge aborts it.
    assign fire = (state == ACCESS) && (cnt == '0) && !rst;

    // Word index wraps modulo DEPTH (a plain slice when DEPTH is a power of two).
    assign idx = IDX_W'(32'(addr_q) % 32'(DEPTH));

`ifdef MEM_RESPONDER_ERR_EN
    logic oob_q;

    // Out-of-range flag captured with the request.
    always_ff @(posedge clk) begin
        if (capture) begin
            oob_q <= (32'(bus.addr) >= 32'(DEPTH));
        end
    end

    assign we    = fire && (rw_q == RW_WRITE) && !oob_q;
    assign re    = fire && (rw_q == RW_READ)  && !oob_q;
    assign rzero = fire && (rw_q == RW_READ)  && oob_q;
`else
    assign we    = fire && (rw_q == RW_WRITE);
    assign re    = fire && (rw_q == RW_READ);
    assign rzero = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.memEN)  state_nxt = ACCESS;
            ACCESS:  if (cnt == '0)  state_nxt = RESP;
            RESP:    if (!bus.memEN) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Wait counter: loaded at capture, drained during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (capture) begin
            cnt <= CNT_W'(WAIT_CYCLES);
        end else if ((state == ACCESS) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Request capture; later changes on addr/wdata/RW are ignored.
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rw_q    <= bus.RW;
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        bus.MFC  = (state == RESP);
        bus.busy = (state != IDLE);
`ifdef MEM_RESPONDER_ERR_EN
        bus.err  = (state == RESP) && oob_q;
`endif
    end

    assign bus.rdata = rdata;

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .re    (re),
        .rzero (rzero),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: unit A (WAIT_CYCLES=2, DEPTH=256) and
// unit B (WAIT_CYCLES=0, DEPTH=16). Honours MEM_RESPONDER_ERR_EN.
module tb_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_a ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_b ();

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set(input int u, input logic en, input logic rw,
                       input logic [7:0] a, input logic [15:0] d);
        if (u == 0) begin
            bus_a.memEN = en; bus_a.RW = rw; bus_a.addr = a; bus_a.wdata = d;
        end else begin
            bus_b.memEN = en; bus_b.RW = rw; bus_b.addr = a; bus_b.wdata = d;
        end
    endtask

    function automatic logic mfc_of(input int u);
        return (u == 0) ? bus_a.MFC : bus_b.MFC;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic [15:0] rdata_of(input int u);
        return (u == 0) ? bus_a.rdata : bus_b.rdata;
    endfunction

    function automatic logic err_of(input int u);
`ifdef MEM_RESPONDER_ERR_EN
        return (u == 0) ? bus_a.err : bus_b.err;
`else
        return (u == 0) ? 1'b0 : 1'b0;
`endif
    endfunction

    // One full handshake. Inputs are scrambled right after capture; MFC
    // latency is counted in rising edges after the capture edge.
    task automatic op(input int u, input logic rw, input logic [7:0] a,
                      input logic [15:0] d, input int hold, input int exp_lat,
                      output logic [15:0] rd, output logic e);
        int lat;
        lat = -1;
        @(negedge clk);
        set(u, 1'b1, rw, a, d);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) set(u, 1'b1, ~rw, ~a, ~d);
            if (mfc_of(u)) begin
                lat = k;
                break;
            end
        end
        chk("mfc_latency", 32'(lat), 32'(exp_lat));
        rd = rdata_of(u);
        e  = err_of(u);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_mfc", 32'(mfc_of(u)), 32'd1);
            chk("hold_busy", 32'(busy_of(u)), 32'd1);
        end
        set(u, 1'b0, rw, a, d);
        @(negedge clk);
        chk("mfc_drop", 32'(mfc_of(u)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        e;
        int          pulses;

        rst_a = 1'b1;
        rst_b = 1'b1;
        set(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        set(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);
        chk("rst_mfc_a", 32'(bus_a.MFC), 32'd0);
        chk("rst_busy_a", 32'(bus_a.busy), 32'd0);
        chk("rst_rdata_a", 32'(bus_a.rdata), 32'h0);
        chk("rst_mfc_b", 32'(bus_b.MFC), 32'd0);
        chk("rst_busy_b", 32'(bus_b.busy), 32'd0);
        chk("rst_rdata_b", 32'(bus_b.rdata), 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Write then read, WAIT_CYCLES=2.
        op(0, RW_WRITE, 8'h10, 16'hBEEF, 0, 3, rd, e);
        chk("wr_keeps_rdata", 32'(rd), 32'h0);
        op(0, RW_READ, 8'h10, 16'h0000, 0, 3, rd, e);
        chk("rd_10", 32'(rd), 32'hBEEF);

        // Held handshake: read and write, memEN held 4 cycles past MFC.
        op(0, RW_READ, 8'h10, 16'h0000, 4, 3, rd, e);
        chk("held_rd_10", 32'(rd), 32'hBEEF);
        op(0, RW_WRITE, 8'h40, 16'hA5A5, 4, 3, rd, e);
        op(0, RW_READ, 8'h40, 16'h0000, 0, 3, rd, e);
        chk("held_wr_40", 32'(rd), 32'hA5A5);

        // Early release during ACCESS of a write.
        @(negedge clk);
        set(0, 1'b1, RW_WRITE, 8'h20, 16'h1234);
        @(negedge clk);
        chk("early_busy", 32'(bus_a.busy), 32'd1);
        set(0, 1'b0, RW_READ, 8'hFF, 16'hFFFF);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus_a.MFC) pulses++;
        end
        chk("early_pulse", 32'(pulses), 32'd1);
        chk("early_rdata_kept", 32'(bus_a.rdata), 32'hA5A5);
        op(0, RW_READ, 8'h20, 16'h0000, 0, 3, rd, e);
        chk("rd_20", 32'(rd), 32'h1234);

        // Reset on the edge that would perform a write to 8'h30.
        op(0, RW_WRITE, 8'h30, 16'h0000, 0, 3, rd, e);
        @(negedge clk);
        set(0, 1'b1, RW_WRITE, 8'h30, 16'hDEAD);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(bus_a.busy), 32'd1);
        rst_a = 1'b1;
        set(0, 1'b0, RW_WRITE, 8'h30, 16'hDEAD);
        @(negedge clk);
        rst_a = 1'b0;
        chk("rst_acc_mfc", 32'(bus_a.MFC), 32'd0);
        chk("rst_acc_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_acc_rdata", 32'(bus_a.rdata), 32'h0);
        op(0, RW_READ, 8'h30, 16'h0000, 0, 3, rd, e);
        chk("rd_30_aborted", 32'(rd), 32'h0000);

        // Reset while in RESP.
        @(negedge clk);
        set(0, 1'b1, RW_READ, 8'h10, 16'h0000);
        repeat (4) @(negedge clk);
        chk("resp_mfc", 32'(bus_a.MFC), 32'd1);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        set(0, 1'b0, RW_READ, 8'h10, 16'h0000);
        chk("rst_resp_mfc", 32'(bus_a.MFC), 32'd0);

        // WAIT_CYCLES=0, DEPTH=16: latency and address range.
        op(1, RW_WRITE, 8'h03, 16'h0333, 0, 1, rd, e);
        op(1, RW_READ, 8'h13, 16'h0000, 0, 1, rd, e);
`ifdef MEM_RESPONDER_ERR_EN
        chk("oob_rd_data", 32'(rd), 32'h0000);
        chk("oob_rd_err", 32'(e), 32'd1);
`else
        chk("wrap_rd_data", 32'(rd), 32'h0333);
`endif
        op(1, RW_WRITE, 8'h13, 16'h7777, 0, 1, rd, e);
`ifdef MEM_RESPONDER_ERR_EN
        chk("oob_wr_err", 32'(e), 32'd1);
        chk("oob_err_clear", 32'(bus_b.err), 32'd0);
`endif
        op(1, RW_READ, 8'h03, 16'h0000, 0, 1, rd, e);
`ifdef MEM_RESPONDER_ERR_EN
        chk("oob_wr_blocked", 32'(rd), 32'h0333);
        chk("inrange_err", 32'(e), 32'd0);
`else
        chk("wrap_wr_data", 32'(rd), 32'h7777);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
